// File: rtl/rng_range_sampler.sv
// Turns raw 32-bit random words into uniform samples in [0, N) by mask-and-reject,
// buffering accepted samples in a small FIFO with saturating reject/drop counters.
module rng_range_sampler #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                rnd,
  input  logic                       rnd_valid,
  input  logic                       cfg_we,
  input  logic [31:0]                cfg_bound,
  output logic [31:0]                out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fill,
  output logic [15:0]                reject_cnt,
  output logic [15:0]                drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  logic [31:0]   bound_q;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   count_q;

  logic [31:0] bound_m1;
  logic [31:0] mask;
  logic [31:0] candidate;
  logic        accept;
  logic        sample;
  logic        push_cand;
  logic        reject;
  logic        full;
  logic        push;
  logic        pop;
  logic        drop;

  // Smear the top set bit of B-1 downward to get the smallest 2^k-1 covering it.
  always_comb begin
    bound_m1 = bound_q - 32'd1;
    mask     = bound_m1 | (bound_m1 >> 1);
    mask     = mask | (mask >> 2);
    mask     = mask | (mask >> 4);
    mask     = mask | (mask >> 8);
    mask     = mask | (mask >> 16);
    if (bound_q == 32'd0) mask = '1;
  end

  // Handshake: rnd is taken whenever rnd_valid=1 (no backpressure); a sample leaves
  // the FIFO on a cycle with out_valid=1 and out_ready=1, and out_data holds otherwise.
  always_comb begin
    candidate = rnd & mask;
    accept    = (bound_q == 32'd0) || (candidate < bound_q);
    sample    = rnd_valid && !cfg_we;
    push_cand = sample && accept;
    reject    = sample && !accept;
    full      = (count_q == DEPTH_L);
    pop       = (count_q != '0) && out_ready && !cfg_we;
    push      = push_cand && (!full || pop);
    drop      = push_cand && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bound_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      reject_cnt <= '0;
      drop_cnt   <= '0;
    end else if (cfg_we) begin
      bound_q <= cfg_bound;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW + 1)'(1);
      else if (pop && !push) count_q <= count_q - (AW + 1)'(1);
      if (reject && reject_cnt != 16'hFFFF) reject_cnt <= reject_cnt + 16'd1;
      if (drop && drop_cnt != 16'hFFFF)     drop_cnt   <= drop_cnt + 16'd1;
    end
  end

  // Storage needs no reset; out_data is gated by occupancy.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wptr_q] <= candidate;
  end

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rptr_q] : 32'd0;
  assign fill      = count_q;

endmodule

// File: doc/rng_range_sampler.md
RNG_RANGE_SAMPLER -- requirements
Module: rng_range_sampler

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning output FIFO entries (power of two, >= 2).
REQ-002 SHALL have port clk  input  1  rising-edge clock; single clock domain.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rnd  input  32  raw random word from the Taus88 core.
REQ-005 SHALL have port rnd_valid  input  1  rnd qualifier; no backpressure to the source.
REQ-006 SHALL have port cfg_we  input  1  load cfg_bound this cycle.
REQ-007 SHALL have port cfg_bound  input  32  exclusive upper bound N; 0 means full 32-bit range.
REQ-008 SHALL have port out_data  output  32  head-of-FIFO sample in [0, N).
REQ-009 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port out_ready  input  1  consumer accepts out_data when out_valid is high.
REQ-011 SHALL have port fill  output  log2(DEPTH)+1  current FIFO occupancy.
REQ-012 SHALL have port reject_cnt  output  16  saturating count of rejected candidates.
REQ-013 SHALL have port drop_cnt  output  16  saturating count of accepted candidates lost to a full FIFO.

Function
REQ-014 SHALL hold bound register B; mask M = all ones if B==0, else smallest 2^k-1 >= B-1 (B==1 gives M=0).
REQ-015 SHALL form candidate c = rnd & M in any cycle with rnd_valid=1 and cfg_we=0.
REQ-016 SHALL accept c iff B==0 or c < B; otherwise reject_cnt increments, saturating at 16'hFFFF.
REQ-017 SHALL push an accepted c at the same clock edge, so out_valid rises the cycle after a sample into an empty FIFO (latency 1).
REQ-018 SHALL pop on out_valid & out_ready; out_data is the oldest entry, stable while out_valid=1 and out_ready=0.
REQ-019 SHALL, with FIFO full and no pop that cycle, discard an accepted c and increment drop_cnt (saturating).
REQ-020 SHALL, with FIFO full and a pop that cycle, perform both push and pop; fill stays DEPTH; no drop.
REQ-021 SHALL, on simultaneous push and pop at any occupancy, leave fill unchanged and preserve order.
REQ-022 SHALL implement read/write pointers modulo DEPTH; wrap-around is invisible at out_data.
REQ-023 SHALL drive out_data = 0 when FIFO empty.
REQ-024 SHALL, on cfg_we=1, load B <= cfg_bound, flush the FIFO (fill=0, out_valid=0 next cycle), ignore rnd that cycle and ignore out_ready that cycle; counters unchanged.
REQ-025 SHALL keep samples uniform over [0, B): no modulo reduction, only mask-and-reject.
REQ-026 SHALL give cfg_we priority over push/pop in the same cycle.

Reset
REQ-027 SHALL, when rst=1 at a clock edge, set B=0, fill=0, out_valid=0, out_data=0, reject_cnt=0, drop_cnt=0, pointers=0.
REQ-028 SHALL give rst priority over cfg_we, push and pop; a reset mid-stream discards all buffered samples.
REQ-029 SHALL accept no sample in the cycle rst is high; first push is possible in the first cycle after rst falls.

Verification
REQ-030 SHALL cover: reset, B=0, rnd=32'hDEADBEEF valid one cycle, out_ready=0 -> next cycle out_valid=1, out_data=32'hDEADBEEF, fill=1.
REQ-031 SHALL cover: B=10 (M=15), rnd low nibbles 3,12,9,15 -> FIFO holds 3,9; reject_cnt=2.
REQ-032 SHALL cover: DEPTH=4, B=0, out_ready=0, 6 valid words -> fill=4, first 4 words retained, drop_cnt=2; then out_ready=1 with 1 new word per cycle -> fill stays 4, drop_cnt stays 2.
REQ-033 SHALL cover: B=1 -> every valid rnd yields out_data=0, reject_cnt=0.
REQ-034 SHALL cover: fill=3, cfg_we=1 with cfg_bound=100 and rnd_valid=1 -> next cycle fill=0, out_valid=0, B=100, M=127.
REQ-035 SHALL cover: 1000 random words with B=6, out_ready random -> every output < 6, output order matches accepted order, accepted+rejected+dropped = valid words input.
